// File: rtl/dp_arb_pkg.sv
// Shared types and sizing for the dot-product engine arbiter.
// A job is six single-precision words, a0..a2 then b0..b2.
package dp_arb_pkg;

    localparam int NUM_REQ       = 4;
    localparam int WORDS_PER_JOB = 6;
    localparam int DATA_W        = 32;
    localparam int IDX_W         = 2;
    localparam int CNT_W         = 3;
    localparam int JOBS_W        = 16;

    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(WORDS_PER_JOB - 1);
    localparam logic [CNT_W-1:0] ALL_WORDS = CNT_W'(WORDS_PER_JOB);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_START,
        ST_STREAM,
        ST_WAIT_RESULT,
        ST_RELEASE,
        ST_RESPOND
    } state_t;

    function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [NUM_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/rr_arbiter4.sv
// Combinational four-way round-robin pick: the search starts at i_ptr
// and wraps, returning a one-hot grant plus its index.
module rr_arbiter4
    import dp_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_any
);

    logic             w_found;
    logic [IDX_W-1:0] w_cand;

    always_comb begin
        o_gnt   = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_cand  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_cand = i_ptr + IDX_W'(k);
            if (!w_found && i_req[w_cand]) begin
                w_found       = 1'b1;
                o_idx         = w_cand;
                o_gnt[w_cand] = 1'b1;
            end
        end
    end

    assign o_any = |i_req;

endmodule

// File: rtl/dp_engine_arbiter.sv
// Shares one dot-product engine among four requesters: collects six
// operand words from the owner, streams them to the engine, returns the result.
module dp_engine_arbiter
    import dp_arb_pkg::*;
(
    input  logic                      iClk,
    input  logic                      iRstn,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        rsp_valid,
    input  logic [NUM_REQ-1:0]        rsp_ready,
    output logic [DATA_W-1:0]         rsp_data,
    input  logic                      eng_ready,
    output logic                      eng_data_valid,
    output logic [DATA_W-1:0]         eng_data,
    input  logic                      eng_calc_done,
    input  logic [DATA_W-1:0]         eng_result,
    output logic                      eng_read_done,
    output logic [IDX_W-1:0]          grant_id,
    output logic                      busy,
    output logic [JOBS_W-1:0]         jobs_done
);

    state_t              r_state;
    logic [IDX_W-1:0]    r_rr_ptr;
    logic [IDX_W-1:0]    r_grant;
    logic [CNT_W-1:0]    r_cnt;
    logic [DATA_W-1:0]   r_buf [WORDS_PER_JOB];
    logic [DATA_W-1:0]   r_result;
    logic [JOBS_W-1:0]   r_jobs_done;
    logic [NUM_REQ-1:0]  r_req_ready;
    logic [NUM_REQ-1:0]  r_rsp_valid;
    logic [DATA_W-1:0]   r_rsp_data;
    logic                r_eng_vld;
    logic [DATA_W-1:0]   r_eng_data;
    logic                r_read_done;

    logic [NUM_REQ-1:0]  w_gnt;
    logic [IDX_W-1:0]    w_gnt_idx;
    logic                w_any;
    logic [DATA_W-1:0]   w_words [NUM_REQ];
    logic [DATA_W-1:0]   w_req_word;

    rr_arbiter4 u_rr (
        .i_req (req_valid),
        .i_ptr (r_rr_ptr),
        .o_gnt (w_gnt),
        .o_idx (w_gnt_idx),
        .o_any (w_any)
    );

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            w_words[i] = req_data[i*DATA_W +: DATA_W];
        end
    end

    assign w_req_word = w_words[r_grant];

    // All outputs are registered and set on state entry, so each is a
    // clean Moore output and drops to zero directly on reset.
    always_ff @(posedge iClk or negedge iRstn) begin
        if (!iRstn) begin
            r_state     <= ST_IDLE;
            r_rr_ptr    <= '0;
            r_grant     <= '0;
            r_cnt       <= '0;
            r_result    <= '0;
            r_jobs_done <= '0;
            r_req_ready <= '0;
            r_rsp_valid <= '0;
            r_rsp_data  <= '0;
            r_eng_vld   <= 1'b0;
            r_eng_data  <= '0;
            r_read_done <= 1'b0;
            for (int i = 0; i < WORDS_PER_JOB; i++) begin
                r_buf[i] <= '0;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any && eng_ready) begin
                        r_grant     <= w_gnt_idx;
                        r_rr_ptr    <= w_gnt_idx + IDX_W'(1);
                        r_req_ready <= w_gnt;
                        r_cnt       <= '0;
                        r_state     <= ST_COLLECT;
                    end
                end
                ST_COLLECT: begin
                    if (req_valid[r_grant]) begin
                        r_buf[r_cnt] <= w_req_word;
                        if (r_cnt == LAST_WORD) begin
                            r_cnt       <= '0;
                            r_req_ready <= '0;
                            r_eng_vld   <= 1'b1;
                            r_eng_data  <= '0;
                            r_state     <= ST_START;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                end
                ST_START: begin
                    r_eng_data <= r_buf[0];
                    r_cnt      <= CNT_W'(1);
                    r_state    <= ST_STREAM;
                end
                // r_cnt is one ahead of the word on eng_data; six beats end at ALL_WORDS.
                ST_STREAM: begin
                    if (r_cnt == ALL_WORDS) begin
                        r_eng_vld  <= 1'b0;
                        r_eng_data <= '0;
                        r_cnt      <= '0;
                        r_state    <= ST_WAIT_RESULT;
                    end else begin
                        r_eng_data <= r_buf[r_cnt];
                        r_cnt      <= r_cnt + CNT_W'(1);
                    end
                end
                ST_WAIT_RESULT: begin
                    if (eng_calc_done) begin
                        r_result    <= eng_result;
                        r_read_done <= 1'b1;
                        r_state     <= ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    if (eng_ready) begin
                        r_read_done <= 1'b0;
                        r_rsp_valid <= onehot(r_grant);
                        r_rsp_data  <= r_result;
                        r_state     <= ST_RESPOND;
                    end
                end
                ST_RESPOND: begin
                    if (rsp_ready[r_grant]) begin
                        r_rsp_valid <= '0;
                        r_rsp_data  <= '0;
                        r_jobs_done <= r_jobs_done + JOBS_W'(1);
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign req_ready      = r_req_ready;
    assign rsp_valid      = r_rsp_valid;
    assign rsp_data       = r_rsp_data;
    assign eng_data_valid = r_eng_vld;
    assign eng_data       = r_eng_data;
    assign eng_read_done  = r_read_done;
    assign grant_id       = r_grant;
    assign busy           = (r_state != ST_IDLE);
    assign jobs_done      = r_jobs_done;

endmodule

// File: tb/tb_dp_engine_arbiter.sv
// Directed bench for dp_engine_arbiter with a behavioural float dot-product engine.
module tb_dp_engine_arbiter;

    logic         iClk = 1'b0;
    logic         iRstn = 1'b0;
    logic [3:0]   req_valid = '0;
    logic [3:0]   req_ready;
    logic [127:0] req_data = '0;
    logic [3:0]   rsp_valid;
    logic [3:0]   rsp_ready = '0;
    logic [31:0]  rsp_data;
    logic         eng_ready = 1'b1;
    logic         eng_data_valid;
    logic [31:0]  eng_data;
    logic         eng_calc_done = 1'b0;
    logic [31:0]  eng_result = '0;
    logic         eng_read_done;
    logic [1:0]   grant_id;
    logic         busy;
    logic [15:0]  jobs_done;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] vec [4][6];
    logic [31:0] exp_res [4];

    dp_engine_arbiter dut (
        .iClk           (iClk),
        .iRstn          (iRstn),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_data       (req_data),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_data       (rsp_data),
        .eng_ready      (eng_ready),
        .eng_data_valid (eng_data_valid),
        .eng_data       (eng_data),
        .eng_calc_done  (eng_calc_done),
        .eng_result     (eng_result),
        .eng_read_done  (eng_read_done),
        .grant_id       (grant_id),
        .busy           (busy),
        .jobs_done      (jobs_done)
    );

    always #5 iClk = ~iClk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Engine model: single<->double conversion is exact for the normal values used here.
    function automatic real s2r(input logic [31:0] s);
        if (s[30:0] == 31'd0) return 0.0;
        return $bitstoreal({s[31], 11'(s[30:23]) + 11'd896, s[22:0], 29'd0});
    endfunction

    function automatic logic [31:0] r2s(input real r);
        logic [63:0] d;
        if (r == 0.0) return 32'd0;
        d = $realtobits(r);
        return {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
    endfunction

    logic        e_busy  = 1'b0;
    int          e_n     = 0;
    int          e_lat   = 0;
    int          e_gaps  = 0;
    int          e_extra = 0;
    logic [31:0] e_wake  = '0;
    logic [31:0] e_w [6];

    always @(posedge iClk or negedge iRstn) begin
        if (!iRstn) begin
            eng_ready     <= 1'b1;
            eng_calc_done <= 1'b0;
            eng_result    <= '0;
            e_busy        <= 1'b0;
            e_n           <= 0;
            e_lat         <= 0;
        end else if (eng_ready && eng_data_valid) begin
            eng_ready <= 1'b0;
            e_busy    <= 1'b1;
            e_n       <= 0;
            e_lat     <= 0;
            e_wake    <= eng_data;
        end else if (e_busy && e_n < 6) begin
            if (eng_data_valid) begin
                e_w[e_n] <= eng_data;
                e_n      <= e_n + 1;
            end else begin
                e_gaps <= e_gaps + 1;
            end
        end else if (e_busy && !eng_calc_done) begin
            if (eng_data_valid) e_extra <= e_extra + 1;
            if (e_lat == 3) begin
                eng_calc_done <= 1'b1;
                eng_result    <= r2s(s2r(e_w[0]) * s2r(e_w[3]) + s2r(e_w[1]) * s2r(e_w[4])
                                     + s2r(e_w[2]) * s2r(e_w[5]));
            end else begin
                e_lat <= e_lat + 1;
            end
        end else if (eng_calc_done && eng_read_done) begin
            eng_calc_done <= 1'b0;
            eng_result    <= '0;
            eng_ready     <= 1'b1;
            e_busy        <= 1'b0;
        end
    end

    // Continuous invariants: idle buses are zero and non-owners never see handshakes.
    always @(negedge iClk) begin
        logic [3:0] own;
        own = busy ? (4'b0001 << grant_id) : 4'b0000;
        chk("eng_data_idle_zero", eng_data_valid ? 32'd0 : eng_data, 32'd0);
        chk("rsp_data_idle_zero", (rsp_valid != 4'd0) ? 32'd0 : rsp_data, 32'd0);
        chk("req_ready_nonowner", {28'd0, req_ready & ~own}, 32'd0);
        chk("rsp_valid_nonowner", {28'd0, rsp_valid & ~own}, 32'd0);
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout required=finish");
        n_bad++;
        $fatal(1, "watchdog");
    end

    task automatic send_job(input int r, input int gap, input int s);
        int n;
        for (int k = 0; k < 6; k++) begin
            req_data[32*r +: 32] = vec[s][k];
            req_valid[r] = 1'b1;
            n = 0;
            while (!req_ready[r] && n < 200) begin
                @(negedge iClk);
                n++;
            end
            chk("collect_wait", {31'd0, n < 200}, 32'd1);
            @(negedge iClk);
            if (gap > 0 && k < 5) begin
                req_valid[r] = 1'b0;
                repeat (gap) @(negedge iClk);
            end
        end
        req_valid[r] = 1'b0;
    endtask

    task automatic get_rsp(input int r, input logic [31:0] expd, input int hold, input logic [15:0] expjobs);
        int n;
        n = 0;
        while (rsp_valid == 4'd0 && n < 1000) begin
            @(negedge iClk);
            n++;
        end
        chk("rsp_wait", {31'd0, n < 1000}, 32'd1);
        chk("rsp_valid", {28'd0, rsp_valid}, 32'd1 << r);
        chk("rsp_data", rsp_data, expd);
        chk("busy_respond", {31'd0, busy}, 32'd1);
        chk("wake_beat_zero", e_wake, 32'd0);
        chk("stream_gaps", e_gaps, 32'd0);
        chk("stream_extra", e_extra, 32'd0);
        for (int h = 0; h < hold; h++) begin
            @(negedge iClk);
            chk("hold_rsp_valid", {28'd0, rsp_valid}, 32'd1 << r);
            chk("hold_rsp_data", rsp_data, expd);
            chk("hold_busy", {31'd0, busy}, 32'd1);
            chk("hold_grant", {30'd0, grant_id}, r);
        end
        rsp_ready[r] = 1'b1;
        @(negedge iClk);
        rsp_ready[r] = 1'b0;
        chk("jobs_done", {16'd0, jobs_done}, {16'd0, expjobs});
        chk("busy_after_ack", {31'd0, busy}, 32'd0);
        chk("rsp_valid_after_ack", {28'd0, rsp_valid}, 32'd0);
    endtask

    initial begin
        vec[0] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000, 32'h40C00000};
        vec[1] = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000};
        vec[2] = '{32'h40000000, 32'h40400000, 32'h00000000, 32'h40800000, 32'h3F800000, 32'h40A00000};
        vec[3] = '{32'h3F000000, 32'h3F800000, 32'h40000000, 32'h40000000, 32'h40000000, 32'h40000000};
        exp_res = '{32'h42000000, 32'h40400000, 32'h41300000, 32'h40E00000};

        repeat (3) @(negedge iClk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_req_ready", {28'd0, req_ready}, 32'd0);
        chk("rst_rsp_valid", {28'd0, rsp_valid}, 32'd0);
        chk("rst_eng_valid", {31'd0, eng_data_valid}, 32'd0);
        chk("rst_read_done", {31'd0, eng_read_done}, 32'd0);
        chk("rst_grant", {30'd0, grant_id}, 32'd0);
        chk("rst_jobs", {16'd0, jobs_done}, 32'd0);
        iRstn = 1'b1;
        @(negedge iClk);

        // Single job from requester 0: 1*4 + 2*5 + 3*6 = 32.0
        send_job(0, 0, 0);
        get_rsp(0, 32'h42000000, 0, 16'd1);

        // Fresh reset, then all four requesting: grants 0,1,2,3
        iRstn = 1'b0;
        @(negedge iClk);
        iRstn = 1'b1;
        chk("rst2_jobs", {16'd0, jobs_done}, 32'd0);
        for (int r = 0; r < 4; r++) req_data[32*r +: 32] = vec[r][0];
        req_valid = 4'hF;
        for (int r = 0; r < 4; r++) begin
            @(negedge iClk);
            chk("rr_grant", {30'd0, grant_id}, r);
            chk("rr_busy", {31'd0, busy}, 32'd1);
            send_job(r, 0, r);
            get_rsp(r, exp_res[r], 0, 16'(r + 1));
        end

        // Owner 0 with 3-cycle gaps between words
        send_job(0, 3, 0);
        get_rsp(0, 32'h42000000, 0, 16'd5);

        // Requester 1 holds rsp_ready low while requester 2 waits
        send_job(1, 0, 1);
        req_data[64 +: 32] = vec[2][0];
        req_valid[2] = 1'b1;
        get_rsp(1, 32'h40400000, 10, 16'd6);
        @(negedge iClk);
        chk("after_hold_grant", {30'd0, grant_id}, 32'd2);
        send_job(2, 0, 2);
        get_rsp(2, 32'h41300000, 0, 16'd7);

        // Reset during STREAM drops the job
        send_job(3, 0, 3);
        @(negedge iClk);
        chk("in_stream_valid", {31'd0, eng_data_valid}, 32'd1);
        chk("in_stream_data", eng_data, vec[3][0]);
        iRstn = 1'b0;
        @(negedge iClk);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_eng_valid", {31'd0, eng_data_valid}, 32'd0);
        chk("mid_rst_eng_data", eng_data, 32'd0);
        chk("mid_rst_req_ready", {28'd0, req_ready}, 32'd0);
        chk("mid_rst_rsp_valid", {28'd0, rsp_valid}, 32'd0);
        chk("mid_rst_rsp_data", rsp_data, 32'd0);
        chk("mid_rst_read_done", {31'd0, eng_read_done}, 32'd0);
        chk("mid_rst_grant", {30'd0, grant_id}, 32'd0);
        chk("mid_rst_jobs", {16'd0, jobs_done}, 32'd0);
        iRstn = 1'b1;
        @(negedge iClk);
        send_job(0, 0, 0);
        get_rsp(0, 32'h42000000, 0, 16'd1);

        // Counter wrap from 0xFFFF
        force dut.r_jobs_done = 16'hFFFF;
        @(negedge iClk);
        release dut.r_jobs_done;
        @(negedge iClk);
        chk("jobs_preload", {16'd0, jobs_done}, 32'h0000FFFF);
        send_job(1, 0, 3);
        get_rsp(1, 32'h40E00000, 0, 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
